// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: prescaled digit stepping, frame-aligned
// value updates through a one-deep holding slot, and leading-zero blanking.
module display_scan_ctrl #(
    parameter int unsigned DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        enable,
    input  logic        blank_lz,
    output logic [3:0]  x,
    output logic [1:0]  dig,
    output logic        en,
    output logic        pending,
    output logic        load_ack
);

    localparam int unsigned CntW = $clog2(DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      dig_q, dig_d;
    logic [15:0]     shown_q, shown_d;
    logic [15:0]     pend_val_q, pend_val_d;
    logic            pending_q, pending_d;
    logic            load_ack_q, load_ack_d;

    logic            tick;
    logic            boundary;
    logic [3:0]      lz;
    logic            blanked;

    assign tick     = (cnt_q == CntMax);
    assign boundary = tick && (dig_q == 2'd3);

    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + CntW'(1);
        dig_d      = tick ? dig_q + 2'd1 : dig_q;
        shown_d    = shown_q;
        pend_val_d = pend_val_q;
        pending_d  = pending_q;
        load_ack_d = 1'b0;
        if (boundary) begin
            // A load landing on the boundary bypasses the slot and wins over it.
            if (load) begin
                shown_d = value;
            end else if (pending_q) begin
                shown_d = pend_val_q;
            end
            pending_d  = 1'b0;
            load_ack_d = load | pending_q;
        end else if (load) begin
            pend_val_d = value;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            dig_q      <= 2'd0;
            shown_q    <= 16'h0000;
            pend_val_q <= 16'h0000;
            pending_q  <= 1'b0;
            load_ack_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dig_q      <= dig_d;
            shown_q    <= shown_d;
            pend_val_q <= pend_val_d;
            pending_q  <= pending_d;
            load_ack_q <= load_ack_d;
        end
    end

    // lz[i]: nibbles 0..i of the shown value are all zero; the last digit always shows.
    always_comb begin
        lz[0] = (shown_q[15:12] == 4'h0);
        lz[1] = lz[0] && (shown_q[11:8] == 4'h0);
        lz[2] = lz[1] && (shown_q[7:4] == 4'h0);
        lz[3] = 1'b0;
    end

    always_comb begin
        x = 4'h0;
        unique case (dig_q)
            2'd0: x = shown_q[15:12];
            2'd1: x = shown_q[11:8];
            2'd2: x = shown_q[7:4];
            2'd3: x = shown_q[3:0];
            default: x = 4'h0;
        endcase
    end

    assign blanked  = blank_lz & lz[dig_q];
    assign en       = enable & ~blanked;
    assign dig      = dig_q;
    assign pending  = pending_q;
    assign load_ack = load_ack_q;

endmodule
